// File: rtl/uart_converter.sv
// uart_converter: 8N1 UART re-timer, PIN_1 at RX baud -> FIFO -> PIN_2 at TX baud
// Ports: CLK clock; RST async active-high reset; PIN_1 serial in (idle high, async);
//        PIN_2 serial out (idle high); LED sticky framing-error / FIFO-overflow flag.
module uart_converter #(
  parameter int DATA_BITS       = 8,
  parameter int RX_CLKS_PER_BIT = 32,
  parameter int TX_CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic PIN_1,
  output logic PIN_2,
  output logic LED
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int RCW = $clog2(RX_CLKS_PER_BIT);
  localparam int TCW = $clog2(TX_CLKS_PER_BIT);
  localparam int IW  = $clog2(DATA_BITS);
  localparam logic [RCW-1:0] R_LAST = RCW'(RX_CLKS_PER_BIT - 1);
  localparam logic [RCW-1:0] R_HALF = RCW'(RX_CLKS_PER_BIT / 2 - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TX_CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]  B_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_t;

  logic s1, rx_s;
  rx_t rstate, rnext;
  logic [RCW-1:0] rcnt;
  logic [IW-1:0] ridx;
  logic [DATA_BITS-1:0] rsh;
  logic r_tick, r_mid, rx_valid, rx_err;
  tx_t tstate, tnext;
  logic [TCW-1:0] tcnt;
  logic [IW-1:0] tidx;
  logic [DATA_BITS-1:0] tsh;
  logic t_tick;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic empty, full, push, pop;

  always_ff @(posedge CLK or posedge RST)
    if (RST) {rx_s, s1} <= 2'b11;
    else {rx_s, s1} <= {s1, PIN_1};

  assign r_tick = rcnt == R_LAST;
  assign r_mid  = rcnt == R_HALF;

  always_ff @(posedge CLK or posedge RST)
    if (RST) rstate <= R_IDLE;
    else rstate <= rnext;

  always_comb begin
    rnext = rstate;
    case (rstate)
      R_IDLE:  rnext = rx_s ? R_IDLE : R_START;
      R_START: rnext = !r_mid ? R_START : rx_s ? R_IDLE : R_DATA;
      R_DATA:  rnext = (r_tick && ridx == B_LAST) ? R_STOP : R_DATA;
      R_STOP:  rnext = !r_tick ? R_STOP : rx_s ? R_IDLE : R_BREAK;
      R_BREAK: rnext = rx_s ? R_IDLE : R_BREAK;
      default: rnext = R_IDLE;
    endcase
  end

  always_comb begin
    rx_valid = rstate == R_STOP && r_tick && rx_s;
    rx_err   = rstate == R_STOP && r_tick && !rx_s;
  end

  // bit counter restarts on every state change and at each data-bit boundary
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rcnt <= '0;
      ridx <= '0;
      rsh  <= '0;
    end else begin
      rcnt <= (rnext != rstate || r_tick) ? '0 : rcnt + 1'b1;
      if (rstate == R_START) ridx <= '0;
      if (rstate == R_DATA && r_tick) begin
        rsh  <= {rx_s, rsh[DATA_BITS-1:1]};
        ridx <= ridx + 1'b1;
      end
    end

  assign empty = wp == rp;
  assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign pop   = tstate == T_IDLE && !empty;
  // a pop in the same cycle frees the slot, so a push to a full FIFO still lands
  assign push  = rx_valid && (!full || pop);

  always_ff @(posedge CLK)
    if (push) mem[wp[AW-1:0]] <= rsh;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wp  <= '0;
      rp  <= '0;
      LED <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (rx_err || (rx_valid && !push)) LED <= 1'b1;
    end

  assign t_tick = tcnt == T_LAST;

  always_ff @(posedge CLK or posedge RST)
    if (RST) tstate <= T_IDLE;
    else tstate <= tnext;

  always_comb begin
    tnext = tstate;
    case (tstate)
      T_IDLE:  tnext = empty ? T_IDLE : T_START;
      T_START: tnext = t_tick ? T_DATA : T_START;
      T_DATA:  tnext = (t_tick && tidx == B_LAST) ? T_STOP : T_DATA;
      T_STOP:  tnext = t_tick ? T_IDLE : T_STOP;
      default: tnext = T_IDLE;
    endcase
  end

  always_comb PIN_2 = tstate == T_START ? 1'b0 : tstate == T_DATA ? tsh[0] : 1'b1;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      tcnt <= '0;
      tidx <= '0;
      tsh  <= '0;
    end else begin
      tcnt <= (tnext != tstate || t_tick) ? '0 : tcnt + 1'b1;
      if (pop) tsh <= mem[rp[AW-1:0]];
      if (tstate == T_START) tidx <= '0;
      if (tstate == T_DATA && t_tick) begin
        tsh  <= tsh >> 1;
        tidx <= tidx + 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_converter.sv
// tb_uart_converter: self-checking bench for uart_converter (default and slow-TX instances)
module tb_uart_converter;
  logic clk = 1'b0, rst = 1'b1, rstb = 1'b1, p1a = 1'b1, p1b = 1'b1;
  logic pin2a, leda, pin2b, ledb;
  int vecs = 0, miss = 0, cyc = 0, stop_cyc = 0;
  logic [7:0] qa[$], qb[$];
  int bada = 0, badb = 0;

  typedef struct {
    bit glitch;
    logic [7:0] d;
    bit stop;
    bit exp_frame;
    bit exp_led;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_converter dut_a (.CLK(clk), .RST(rst), .PIN_1(p1a), .PIN_2(pin2a), .LED(leda));
  uart_converter #(.TX_CLKS_PER_BIT(64)) dut_b (.CLK(clk), .RST(rstb), .PIN_1(p1b), .PIN_2(pin2b), .LED(ledb));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic pin(input bit w);
    return w ? pin2b : pin2a;
  endfunction

  task automatic drive(input bit w, input logic v);
    if (w) p1b = v;
    else p1a = v;
  endtask

  task automatic send(input bit w, input logic [7:0] d, input bit stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) stop_cyc = cyc;
      drive(w, f[i]);
      repeat (32) @(negedge clk);
    end
    drive(w, 1'b1);
  endtask

  task automatic rx_frame(input bit w, input int cpb, output logic [7:0] d, output bit ok);
    ok = 1'b1;
    repeat (cpb / 2) @(negedge clk);
    if (pin(w) !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk);
      d[i] = pin(w);
    end
    repeat (cpb) @(negedge clk);
    if (pin(w) !== 1'b1) ok = 1'b0;
  endtask

  initial forever begin : mon_a
    logic [7:0] d;
    bit ok;
    @(negedge pin2a);
    rx_frame(1'b0, 16, d, ok);
    if (ok) qa.push_back(d);
    else bada++;
  end

  initial forever begin : mon_b
    logic [7:0] d;
    bit ok;
    @(negedge pin2b);
    rx_frame(1'b1, 64, d, ok);
    if (ok) qb.push_back(d);
    else badb++;
  end

  initial begin
    logic [7:0] exp_q[$], sb[$];
    int lows, lat, n, j;
    bit ok;
    tbl = '{'{0, 8'h5C, 1, 1, 0}, '{0, 8'hA5, 1, 1, 0}, '{1, 8'h00, 0, 0, 0},
            '{0, 8'hFF, 1, 1, 0}, '{0, 8'h00, 1, 1, 0}, '{0, 8'h00, 0, 0, 1},
            '{0, 8'h41, 1, 1, 1}};
    repeat (5) @(negedge clk);
    chk("rst_pin2", pin2a, 1);
    chk("rst_led", leda, 0);
    chk("rst_pin2_b", pin2b, 1);
    chk("rst_led_b", ledb, 0);
    rst = 1'b0;
    rstb = 1'b0;
    lows = 0;
    repeat (1000) begin
      @(negedge clk);
      if (pin2a !== 1'b1 || pin2b !== 1'b1) lows++;
    end
    chk("idle_quiet", lows, 0);

    qa.delete();
    lat = -1;
    fork
      send(1'b0, 8'h5C, 1'b1);
      begin
        n = 0;
        @(posedge clk);
        #1;
        while (pin2a === 1'b1 && n < 1000) begin
          @(posedge clk);
          #1;
          n++;
        end
        lat = cyc - stop_cyc;
      end
    join
    vecs++;
    if (lat < 16 || lat > 23) begin
      miss++;
      $display("FAIL latency: got %0d cycles from stop-bit start, required 16..23", lat);
    end
    repeat (300) @(negedge clk);
    chk("single_count", qa.size(), 1);
    chk("single_byte", qa.size() > 0 ? qa[0] : 8'hxx, 8'h5C);

    qa.delete();
    for (int i = 0; i < 60; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      send(1'b0, b, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    n = 0;
    while (qa.size() < exp_q.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("stream_count", qa.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < qa.size(); i++) chk($sformatf("stream_byte%0d", i), qa[i], exp_q[i]);
    chk("stream_led", leda, 0);
    chk("stream_txframe_err", bada, 0);

    for (int i = 0; i < 7; i++) begin
      qa.delete();
      if (tbl[i].glitch) begin
        @(negedge clk);
        p1a = 1'b0;
        repeat (8) @(negedge clk);
        p1a = 1'b1;
      end else send(1'b0, tbl[i].d, tbl[i].stop);
      repeat (300) @(negedge clk);
      chk($sformatf("vec%0d_count", i), qa.size(), tbl[i].exp_frame);
      if (tbl[i].exp_frame) chk($sformatf("vec%0d_byte", i), qa.size() > 0 ? qa[0] : 8'hxx, tbl[i].d);
      chk($sformatf("vec%0d_led", i), leda, tbl[i].exp_led);
    end

    qb.delete();
    for (int i = 0; i < 48; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      sb.push_back(b);
      send(1'b1, b, 1'b1);
    end
    n = 0;
    lows = 0;
    while (lows < 2000 && n < 40000) begin
      @(negedge clk);
      n++;
      lows = pin2b === 1'b1 ? lows + 1 : 0;
    end
    chk("ovf_led", ledb, 1);
    chk("ovf_txframe_err", badb, 0);
    chk("ovf_at_least_17", qb.size() >= 17, 1);
    chk("ovf_some_dropped", qb.size() < 48, 1);
    for (int i = 0; i < 17; i++) chk($sformatf("ovf_head%0d", i), i < qb.size() ? qb[i] : 8'hxx, sb[i]);
    ok = 1'b1;
    j = 0;
    foreach (qb[i]) begin
      while (j < sb.size() && sb[j] !== qb[i]) j++;
      if (j >= sb.size()) ok = 1'b0;
      j++;
    end
    chk("ovf_in_order", ok, 1);

    for (int i = 0; i < 5; i++) send(1'b1, 8'($urandom), 1'b1);
    n = 0;
    while (pin2b === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midframe_seen", pin2b, 0);
    repeat (20) @(negedge clk);
    #2 rstb = 1'b1;
    #1;
    chk("midrst_pin2", pin2b, 1);
    chk("midrst_led", ledb, 0);
    repeat (3) @(negedge clk);
    rstb = 1'b0;
    lows = 0;
    repeat (2000) begin
      @(negedge clk);
      if (pin2b !== 1'b1) lows++;
    end
    chk("midrst_fifo_empty", lows, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
